// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of a single-port data memory.
// Memory control, address and write data come only from registered state.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        C_req,
    input  logic        C_we,
    input  logic [15:0] C_addr,
    input  logic [15:0] C_wdata,
    output logic        C_gnt,
    output logic        C_rvalid,
    output logic [15:0] C_rdata,
    output logic        C_err,
    input  logic        D_req,
    input  logic        D_we,
    input  logic [15:0] D_addr,
    input  logic [15:0] D_wdata,
    output logic        D_gnt,
    output logic        D_rvalid,
    output logic [15:0] D_rdata,
    output logic        D_err,
    output logic        Memwrite,
    output logic        Memread,
    output logic        Memtoreg,
    output logic [15:0] addr,
    output logic [15:0] Datawrite,
    input  logic [15:0] Readdata
);

    // state  | meaning
    // IDLE   | no access in flight; arbitrate on every edge
    // ACCESS | memory driven for the winner; winner's gnt high
    // RESP   | winner's rvalid high; arbitrate again
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q;      // 1 = port D won the most recent grant
    logic        port_q;      // 1 = port D owns the access in flight
    logic        we_q;
    logic        oor_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;

    logic        arb;
    logic        win_c;
    logic        win_d;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    always_comb begin
        win_c     = C_req & (~D_req | last_q);
        win_d     = D_req & ~win_c;
        arb       = (state_q != ACCESS) & (C_req | D_req);
        sel_we    = win_d ? D_we    : C_we;
        sel_addr  = win_d ? D_addr  : C_addr;
        sel_wdata = win_d ? D_wdata : C_wdata;

        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arb ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = arb ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (arb) begin
                last_q  <= win_d;
                port_q  <= win_d;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                oor_q   <= (32'(sel_addr) >= DEPTH);
            end
            if (state_q == ACCESS) begin
                rdata_q <= (we_q | oor_q) ? 16'h0000 : Readdata;
            end
        end
    end

    // Strobes decode from the state register so reset drops them without waiting for an edge.
    always_comb begin
        Memwrite  = (state_q == ACCESS) & we_q & ~oor_q;
        Memread   = (state_q == ACCESS) & ~we_q & ~oor_q;
        Memtoreg  = (state_q == ACCESS) & ~we_q;
        addr      = addr_q;
        Datawrite = wdata_q;

        C_gnt    = (state_q == ACCESS) & ~port_q;
        D_gnt    = (state_q == ACCESS) & port_q;
        C_rvalid = (state_q == RESP) & ~port_q;
        D_rvalid = (state_q == RESP) & port_q;
        C_err    = C_rvalid & oor_q;
        D_err    = D_rvalid & oor_q;
        C_rdata  = C_rvalid ? rdata_q : 16'h0000;
        D_rdata  = D_rvalid ? rdata_q : 16'h0000;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 16-word memory attached.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        C_req, C_we, D_req, D_we;
    logic [15:0] C_addr, C_wdata, D_addr, D_wdata;
    logic        C_gnt, C_rvalid, C_err, D_gnt, D_rvalid, D_err;
    logic [15:0] C_rdata, D_rdata;
    logic        Memwrite, Memread, Memtoreg;
    logic [15:0] addr, Datawrite, Readdata;

    logic [15:0] mem [16];

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.DEPTH(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .C_req(C_req), .C_we(C_we), .C_addr(C_addr), .C_wdata(C_wdata),
        .C_gnt(C_gnt), .C_rvalid(C_rvalid), .C_rdata(C_rdata), .C_err(C_err),
        .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_gnt(D_gnt), .D_rvalid(D_rvalid), .D_rdata(D_rdata), .D_err(D_err),
        .Memwrite(Memwrite), .Memread(Memread), .Memtoreg(Memtoreg),
        .addr(addr), .Datawrite(Datawrite), .Readdata(Readdata)
    );

    assign Readdata = (addr < 16'd16) ? mem[addr[3:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (Memwrite) mem[addr[3:0]] <= Datawrite;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, " C_gnt"}, C_gnt, 1'b0);
        check1({tag, " D_gnt"}, D_gnt, 1'b0);
        check1({tag, " C_rvalid"}, C_rvalid, 1'b0);
        check1({tag, " D_rvalid"}, D_rvalid, 1'b0);
        check1({tag, " C_err"}, C_err, 1'b0);
        check1({tag, " D_err"}, D_err, 1'b0);
        check16({tag, " C_rdata"}, C_rdata, 16'h0000);
        check16({tag, " D_rdata"}, D_rdata, 16'h0000);
        check1({tag, " Memwrite"}, Memwrite, 1'b0);
        check1({tag, " Memread"}, Memread, 1'b0);
        check1({tag, " Memtoreg"}, Memtoreg, 1'b0);
        check16({tag, " addr"}, addr, 16'h0000);
        check16({tag, " Datawrite"}, Datawrite, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'd20;
        mem[1] = 16'd5;
        mem[2] = 16'd15;

        Rst_n = 1'b0;
        C_req = 1'b0; C_we = 1'b0; C_addr = 16'h0; C_wdata = 16'h0;
        D_req = 1'b0; D_we = 1'b0; D_addr = 16'h0; D_wdata = 16'h0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // single read of addr 2 on port C
        C_req = 1'b1; C_we = 1'b0; C_addr = 16'd2;
        step();
        check1("rd C_gnt", C_gnt, 1'b1);
        check1("rd D_gnt", D_gnt, 1'b0);
        check1("rd Memread", Memread, 1'b1);
        check1("rd Memtoreg", Memtoreg, 1'b1);
        check1("rd Memwrite", Memwrite, 1'b0);
        check16("rd addr", addr, 16'd2);
        C_req = 1'b0;
        step();
        check1("rd C_rvalid", C_rvalid, 1'b1);
        check16("rd C_rdata", C_rdata, 16'd15);
        check1("rd C_err", C_err, 1'b0);
        check1("rd D_rvalid", D_rvalid, 1'b0);
        check1("rd C_gnt off", C_gnt, 1'b0);
        step();
        check1("rd idle C_rvalid", C_rvalid, 1'b0);

        // port D writes 0x1234 to addr 5 then reads it back
        D_req = 1'b1; D_we = 1'b1; D_addr = 16'd5; D_wdata = 16'h1234;
        step();
        check1("wr D_gnt", D_gnt, 1'b1);
        check1("wr C_gnt", C_gnt, 1'b0);
        check1("wr Memwrite", Memwrite, 1'b1);
        check1("wr Memread", Memread, 1'b0);
        check1("wr Memtoreg", Memtoreg, 1'b0);
        check16("wr addr", addr, 16'd5);
        check16("wr Datawrite", Datawrite, 16'h1234);
        D_we = 1'b0;
        step();
        check1("wr D_rvalid", D_rvalid, 1'b1);
        check1("wr D_err", D_err, 1'b0);
        check16("wr D_rdata", D_rdata, 16'h0000);
        check1("wr Memwrite one cycle", Memwrite, 1'b0);
        check1("wr C_rvalid", C_rvalid, 1'b0);
        check16("wr mem[5]", mem[5], 16'h1234);
        step();
        check1("rb D_gnt", D_gnt, 1'b1);
        check1("rb Memread", Memread, 1'b1);
        check1("rb Memwrite", Memwrite, 1'b0);
        check1("rb C_gnt", C_gnt, 1'b0);
        D_req = 1'b0;
        step();
        check1("rb D_rvalid", D_rvalid, 1'b1);
        check16("rb D_rdata", D_rdata, 16'h1234);
        check1("rb C_rvalid", C_rvalid, 1'b0);
        check16("rb C_rdata", C_rdata, 16'h0000);
        step();

        // out-of-range read at addr 16, then write at 0xFFFF
        C_req = 1'b1; C_we = 1'b0; C_addr = 16'd16;
        step();
        check1("oor rd C_gnt", C_gnt, 1'b1);
        check1("oor rd Memread", Memread, 1'b0);
        check1("oor rd Memwrite", Memwrite, 1'b0);
        C_req = 1'b0;
        step();
        check1("oor rd C_rvalid", C_rvalid, 1'b1);
        check1("oor rd C_err", C_err, 1'b1);
        check16("oor rd C_rdata", C_rdata, 16'h0000);
        C_req = 1'b1; C_we = 1'b1; C_addr = 16'hFFFF; C_wdata = 16'hABCD;
        step();
        check1("oor wr C_gnt", C_gnt, 1'b1);
        check1("oor wr Memwrite", Memwrite, 1'b0);
        check1("oor wr Memread", Memread, 1'b0);
        C_req = 1'b0;
        step();
        check1("oor wr C_rvalid", C_rvalid, 1'b1);
        check1("oor wr C_err", C_err, 1'b1);
        check16("oor wr C_rdata", C_rdata, 16'h0000);
        check16("oor wr mem[15]", mem[15], 16'h010F);
        step();
        check1("oor idle C_err", C_err, 1'b0);

        // reset pulled during a port D write
        D_req = 1'b1; D_we = 1'b1; D_addr = 16'd3; D_wdata = 16'h5555;
        step();
        check1("rst Memwrite before", Memwrite, 1'b1);
        D_req = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        check1("rst Memwrite dropped", Memwrite, 1'b0);
        check1("rst D_gnt dropped", D_gnt, 1'b0);
        step();
        check1("rst D_rvalid", D_rvalid, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check_all_zero("post-rst");
        check16("rst mem[3]", mem[3], 16'h0103);

        // both ports read continuously: grants alternate, C first
        C_req = 1'b1; C_we = 1'b0; C_addr = 16'd0;
        D_req = 1'b1; D_we = 1'b0; D_addr = 16'd1;
        @(posedge Clk);
        #1;
        for (int k = 1; k <= 8; k++) begin
            logic to_c;
            to_c = ((k - 1) % 4) < 2;
            check1($sformatf("tie%0d C_gnt", k), C_gnt, (k % 2 == 1) && to_c);
            check1($sformatf("tie%0d D_gnt", k), D_gnt, (k % 2 == 1) && !to_c);
            check1($sformatf("tie%0d C_rvalid", k), C_rvalid, (k % 2 == 0) && to_c);
            check1($sformatf("tie%0d D_rvalid", k), D_rvalid, (k % 2 == 0) && !to_c);
            check16($sformatf("tie%0d C_rdata", k), C_rdata,
                    ((k % 2 == 0) && to_c) ? 16'd20 : 16'd0);
            check16($sformatf("tie%0d D_rdata", k), D_rdata,
                    ((k % 2 == 0) && !to_c) ? 16'd5 : 16'd0);
            if (k == 8) begin
                C_req = 1'b0;
                D_req = 1'b0;
            end
            step();
        end
        check1("tie idle C_gnt", C_gnt, 1'b0);
        check1("tie idle D_gnt", D_gnt, 1'b0);

        // back-to-back reads on port C: addr 0 then addr 1
        C_req = 1'b1; C_we = 1'b0; C_addr = 16'd0;
        step();
        check1("b2b c1 C_gnt", C_gnt, 1'b1);
        check16("b2b c1 addr", addr, 16'd0);
        C_addr = 16'd1;
        step();
        check1("b2b c2 C_rvalid", C_rvalid, 1'b1);
        check16("b2b c2 C_rdata", C_rdata, 16'd20);
        step();
        check1("b2b c3 C_gnt", C_gnt, 1'b1);
        check16("b2b c3 addr", addr, 16'd1);
        C_req = 1'b0;
        step();
        check1("b2b c4 C_rvalid", C_rvalid, 1'b1);
        check16("b2b c4 C_rdata", C_rdata, 16'd5);
        step();
        check1("b2b idle C_rvalid", C_rvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
